fir_tap_sequencer: RTL and testbench

Drive side of the 3-tap FIR filter's coefficient-load and sample interface. The block stores three 8-bit coefficients written by a configuration port. On a start request it resets the filter and replays the coefficients, one per cycle, in the filter's load window. It then streams buffered input samples to the filter every cycle, inserting zeros and flagging underrun when its 4-entry FIFO runs dry. It sits between the sample source/config logic and the filter core.

---
 rtl/fir_pkg.sv | 15 +
 rtl/sample_fifo.sv | 59 +++++
 rtl/fir_tap_sequencer.sv | 113 +++++++++++
 tb/tb_fir_tap_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the 3-tap FIR filter and its drive-side sequencer.
package fir_pkg;
  localparam int NTAPS  = 3;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FRST   = 3'd1,
    LOAD0  = 3'd2,
    LOAD1  = 3'd3,
    LOAD2  = 3'd4,
    STREAM = 3'd5
  } state_e;
endpackage

// File: rtl/sample_fifo.sv
// Power-of-two sample FIFO; pointers wrap naturally, count is one bit wider than the pointers.
module sample_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = wptr_q + PTR_ONE;
    if (pop_i)  rptr_d = rptr_q + PTR_ONE;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
endmodule

// File: rtl/fir_tap_sequencer.sv
// Coefficient loader and sample streamer for the 3-tap FIR core: reset, replay h0..h2, then stream.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [COEF_W-1:0] cfg_data,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              filt_rst,
  output logic [COEF_W-1:0] coef_out,
  output logic [DATA_W-1:0] x_out,
  output logic              busy,
  output logic              underrun
);
  localparam logic [1:0] LAST_TAP = 2'(NTAPS - 1);

  state_e state_q, state_d;
  logic [NTAPS-1:0][COEF_W-1:0] h_q, h_d;
  logic [NTAPS-1:0][COEF_W-1:0] snap_q, snap_d;
  logic              filt_rst_q, filt_rst_d;
  logic [COEF_W-1:0] coef_q, coef_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic              busy_q, busy_d;
  logic              underrun_q, underrun_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  assign s_ready   = ~fifo_full;
  assign fifo_push = s_valid & ~fifo_full;

  sample_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (s_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Outputs are registered from the next state so each shows in the cycle its state is entered.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = FRST;
    end else begin
      case (state_q)
        FRST:    state_d = LOAD0;
        LOAD0:   state_d = LOAD1;
        LOAD1:   state_d = LOAD2;
        LOAD2:   state_d = STREAM;
        default: state_d = state_q;
      endcase
    end

    h_d = h_q;
    if (cfg_we && (cfg_addr <= LAST_TAP)) h_d[cfg_addr] = cfg_data;
    // The load replays a snapshot taken at start, so mid-load writes wait for the next start.
    snap_d = start ? h_q : snap_q;

    fifo_pop   = (state_d == STREAM) && !fifo_empty;
    filt_rst_d = (state_d == IDLE) || (state_d == FRST);
    busy_d     = (state_d == FRST) || (state_d == LOAD0) ||
                 (state_d == LOAD1) || (state_d == LOAD2);
    coef_d = '0;
    case (state_d)
      LOAD0:   coef_d = snap_q[0];
      LOAD1:   coef_d = snap_q[1];
      LOAD2:   coef_d = snap_q[2];
      default: coef_d = '0;
    endcase
    x_d        = fifo_pop ? fifo_rdata : '0;
    underrun_d = start ? 1'b0 :
                 (underrun_q | ((state_d == STREAM) && fifo_empty));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      h_q        <= '0;
      snap_q     <= '0;
      filt_rst_q <= 1'b1;
      coef_q     <= '0;
      x_q        <= '0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      snap_q     <= snap_d;
      filt_rst_q <= filt_rst_d;
      coef_q     <= coef_d;
      x_q        <= x_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
    end
  end

  assign filt_rst = filt_rst_q;
  assign coef_out = coef_q;
  assign x_out    = x_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer with hand-computed expectations.
module tb_fir_tap_sequencer;
  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       start;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       filt_rst;
  logic [7:0] coef_out;
  logic [7:0] x_out;
  logic       busy;
  logic       underrun;

  int n_chk = 0;
  int n_err = 0;

  fir_tap_sequencer #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .start    (start),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .filt_rst (filt_rst),
    .coef_out (coef_out),
    .x_out    (x_out),
    .busy     (busy),
    .underrun (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_filt_rst"}, filt_rst, 1);
    check({tag, "_coef"},     coef_out, 0);
    check({tag, "_x"},        x_out,    0);
    check({tag, "_s_ready"},  s_ready,  1);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_underrun"}, underrun, 0);
  endtask

  task automatic write_coef(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    logic [7:0] samp [6];
    samp[0] = 8'd10; samp[1] = 8'd20; samp[2] = 8'd30;
    samp[3] = 8'd40; samp[4] = 8'd50; samp[5] = 8'd60;

    rst_n = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; s_valid = 1'b0; s_data = '0;
    #3 rst_n = 1'b0;
    step(); step();
    check_reset_vals("rst");
    @(negedge clk) rst_n = 1'b1;
    step();
    check_reset_vals("idle");

    // Coefficient load 3,5,7; address 3 must be ignored.
    write_coef(2'd0, 8'd3);
    write_coef(2'd1, 8'd5);
    write_coef(2'd2, 8'd7);
    write_coef(2'd3, 8'd99);
    start = 1'b1; step(); start = 1'b0;
    check("frst_filt_rst", filt_rst, 1);
    check("frst_busy", busy, 1);
    check("frst_coef", coef_out, 0);
    step();
    check("load0_coef", coef_out, 3);
    check("load0_filt_rst", filt_rst, 0);
    step();
    check("load1_coef", coef_out, 5);
    step();
    check("load2_coef", coef_out, 7);
    check("load2_busy", busy, 1);
    step();
    check("stream_busy", busy, 0);
    check("stream_coef", coef_out, 0);
    check("empty_x0", x_out, 0);
    check("empty_underrun0", underrun, 1);
    step();
    check("empty_x1", x_out, 0);
    check("empty_underrun1", underrun, 1);

    // Restart clears underrun; samples fed continuously keep the stream fed.
    start = 1'b1; step(); start = 1'b0;
    check("restart_underrun_clr", underrun, 0);
    check("restart_filt_rst", filt_rst, 1);
    for (int i = 0; i < 10; i++) begin
      if (i < 6) begin
        s_valid = 1'b1; s_data = samp[i];
      end else begin
        s_valid = 1'b0;
      end
      step();
      if (i >= 3 && i <= 8) begin
        check($sformatf("stream_x%0d", i - 3), x_out, samp[i-3]);
        check($sformatf("stream_nounder%0d", i - 3), underrun, 0);
      end
    end
    step();
    check("drain_x", x_out, 0);
    check("drain_underrun", underrun, 1);

    // Push into an empty FIFO while streaming: two-cycle latency.
    s_valid = 1'b1; s_data = 8'd77; step(); s_valid = 1'b0;
    check("lat_x_m", x_out, 0);
    step();
    check("lat_x_m1", x_out, 77);
    step();
    check("lat_x_m2", x_out, 0);

    // Restart in LOAD1; FIFO contents survive; snapshot semantics of config writes.
    start = 1'b1; step(); start = 1'b0;
    s_valid = 1'b1; s_data = 8'd11;
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 8'd9;
    step();
    check("r_load0_coef", coef_out, 3);
    cfg_we = 1'b0; s_data = 8'd22;
    step();
    check("r_load1_coef", coef_out, 5);
    s_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    check("r_frst_filt_rst", filt_rst, 1);
    check("r_frst_coef", coef_out, 0);
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 8'd100;
    step();
    cfg_we = 1'b0;
    check("r2_load0_coef", coef_out, 3);
    step();
    check("r2_load1_coef", coef_out, 9);
    step();
    check("r2_load2_coef", coef_out, 7);
    step();
    check("r2_x0", x_out, 11);
    check("r2_busy", busy, 0);
    step();
    check("r2_x1", x_out, 22);
    check("r2_nounder", underrun, 0);
    step();
    check("r2_x2", x_out, 0);
    check("r2_under", underrun, 1);

    // Async reset mid-stream with two samples still queued.
    start = 1'b1; step(); start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      s_valid = 1'b1; s_data = 8'(i);
      step();
    end
    s_valid = 1'b0;
    step();
    check("pre_arst_x", x_out, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    step(); step();
    @(negedge clk) rst_n = 1'b1;

    // Fill in IDLE: fifth sample refused, then four stream in order with zero coefficients.
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 8'(101 + i);
      step();
      check($sformatf("fill_s_ready%0d", i), s_ready, (i >= 3) ? 0 : 1);
    end
    s_valid = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("zero_coef%0d", k), coef_out, 0);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("fill_x%0d", i), x_out, 101 + i);
      check($sformatf("fill_nounder%0d", i), underrun, 0);
    end
    check("fill_s_ready_after", s_ready, 1);
    step();
    check("fill_x_end", x_out, 0);
    check("fill_under_end", underrun, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
